// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and the scan-code (set 2) to lowercase ASCII map.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK      = 8'hF0;
  localparam logic [7:0] PS2_EXT        = 8'hE0;
  localparam int         PS2_FRAME_BITS = 11;

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    case (code)
      8'h1C: a = "a";  8'h32: a = "b";  8'h21: a = "c";  8'h23: a = "d";
      8'h24: a = "e";  8'h2B: a = "f";  8'h34: a = "g";  8'h33: a = "h";
      8'h43: a = "i";  8'h3B: a = "j";  8'h42: a = "k";  8'h4B: a = "l";
      8'h3A: a = "m";  8'h31: a = "n";  8'h44: a = "o";  8'h4D: a = "p";
      8'h15: a = "q";  8'h2D: a = "r";  8'h1B: a = "s";  8'h2C: a = "t";
      8'h3C: a = "u";  8'h2A: a = "v";  8'h1D: a = "w";  8'h22: a = "x";
      8'h35: a = "y";  8'h1A: a = "z";
      8'h45: a = "0";  8'h16: a = "1";  8'h1E: a = "2";  8'h26: a = "3";
      8'h25: a = "4";  8'h2E: a = "5";  8'h36: a = "6";  8'h3D: a = "7";
      8'h3E: a = "8";  8'h46: a = "9";
      8'h29: a = 8'h20;
      8'h5A: a = 8'h0D;
      default: a = 8'h00;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/ps2_kbd_decoder_frame_rx.sv
// PS/2 frame receiver: synchronizes the pins, shifts 11-bit frames, emits checked bytes.
// Optional PS2_FRAME_TIMEOUT_EN adds a watchdog that drops stalled partial frames.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid
);

  logic [2:0] clk_sync_q, clk_sync_d;
  logic [2:0] dat_sync_q, dat_sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [9:0] shift_q, shift_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d;
  logic       fall;
  logic       data_bit;

  assign fall     = clk_prev_q & ~clk_sync_q[2];
  assign data_bit = dat_sync_q[2];

`ifdef PS2_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          timed_out;
  assign timed_out = (bit_cnt_q != 4'd0) && (idle_q >= TW'(TIMEOUT_CYCLES));
`endif

  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_data};
    clk_prev_d = clk_sync_q[2];
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
`ifdef PS2_FRAME_TIMEOUT_EN
    idle_d = (idle_q == {TW{1'b1}}) ? idle_q : idle_q + 1'b1;
`endif
    if (fall) begin
`ifdef PS2_FRAME_TIMEOUT_EN
      idle_d = '0;
`endif
      if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
        // shift_q holds start at [0], D0..D7 at [8:1], parity at [9]
        bit_cnt_d = 4'd0;
        if (!shift_q[0] && data_bit && (^shift_q[9:1])) begin
          byte_d  = shift_q[8:1];
          valid_d = 1'b1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q + 4'd1;
        shift_d   = {data_bit, shift_q[9:1]};
      end
    end
`ifdef PS2_FRAME_TIMEOUT_EN
    else if (timed_out) begin
      bit_cnt_d = 4'd0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync_q <= 3'b000;
      dat_sync_q <= 3'b000;
      clk_prev_q <= 1'b0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 10'd0;
      byte_q     <= 8'd0;
      valid_q    <= 1'b0;
`ifdef PS2_FRAME_TIMEOUT_EN
      idle_q     <= '0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
`ifdef PS2_FRAME_TIMEOUT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard front end: tracks the held key, its ASCII code and a press count.
// Define PS2_FRAME_TIMEOUT_EN to enable the partial-frame watchdog in the receiver.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] real_data,
  output logic [7:0] ascii,
  output logic [7:0] num
);

  logic [7:0] rx_byte;
  logic       rx_valid;

  logic [7:0] real_data_q, real_data_d;
  logic [7:0] ascii_q, ascii_d;
  logic [7:0] num_q, num_d;
  logic       break_q, break_d;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid)
  );

  always_comb begin
    real_data_d = real_data_q;
    num_d       = num_q;
    break_d     = break_q;
    ascii_d     = scan_to_ascii(real_data_q);
    if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        // extended prefix carries no information for this display path
      end else if (rx_byte == PS2_BREAK) begin
        break_d = 1'b1;
      end else if (break_q) begin
        real_data_d = 8'h00;
        break_d     = 1'b0;
      end else if (rx_byte != real_data_q) begin
        real_data_d = rx_byte;
        num_d       = num_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      real_data_q <= 8'h00;
      ascii_q     <= 8'h00;
      num_q       <= 8'h00;
      break_q     <= 1'b0;
    end else begin
      real_data_q <= real_data_d;
      ascii_q     <= ascii_d;
      num_q       <= num_d;
      break_q     <= break_d;
    end
  end

  assign real_data = real_data_q;
  assign ascii     = ascii_q;
  assign num       = num_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Scoreboard bench: stimulus queues expected output tuples, a monitor checks each output change.
module tb_ps2_kbd_decoder;

  localparam int TO_CYC = 200;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] real_data, ascii, num;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic        mon_en = 1'b0;

  ps2_kbd_decoder #(.TIMEOUT_CYCLES(TO_CYC)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .real_data (real_data),
    .ascii     (ascii),
    .num       (num)
  );

  always #5 clk = ~clk;

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    #40 ps2_clk = 1'b0;
    #40 ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par = 1'b0);
    logic par;
    par = ~(^b) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    #200;
  endtask

  task automatic expect_out(input logic [7:0] r, input logic [7:0] a, input logic [7:0] n);
    exp_q.push_back({r, a, n});
  endtask

  // Monitor: any change in outputs is one presented response; settle for ascii lag then compare.
  initial begin : monitor
    logic [23:0] last, cur, exp;
    last = 24'h0;
    forever begin
      @(negedge clk);
      cur = {real_data, ascii, num};
      if (mon_en && cur != last) begin
        repeat (3) @(negedge clk);
        cur = {real_data, ascii, num};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got real=%02h ascii=%02h num=%02h, none expected",
                   cur[23:16], cur[15:8], cur[7:0]);
        end else begin
          exp = exp_q.pop_front();
          if (cur != exp) begin
            errors++;
            $display("FAIL output got real=%02h ascii=%02h num=%02h want real=%02h ascii=%02h num=%02h",
                     cur[23:16], cur[15:8], cur[7:0], exp[23:16], exp[15:8], exp[7:0]);
          end else begin
            $display("ok real=%02h ascii=%02h num=%02h", cur[23:16], cur[15:8], cur[7:0]);
          end
        end
        last = cur;
      end
    end
  end

  initial begin : stim
    logic [7:0] n;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({real_data, ascii, num} != 24'h0) begin
      errors++;
      $display("FAIL reset got real=%02h ascii=%02h num=%02h want 00 00 00", real_data, ascii, num);
    end else begin
      $display("ok reset real=00 ascii=00 num=00");
    end
    mon_en = 1'b1;

    expect_out(8'h1C, 8'h61, 8'h01); send(8'h1C);
    send(8'hF0);
    expect_out(8'h00, 8'h00, 8'h01); send(8'h1C);

    expect_out(8'h1B, 8'h73, 8'h02); send(8'h1B);
    send(8'h1B);
    send(8'h1B);
    send(8'hF0);
    expect_out(8'h00, 8'h00, 8'h02); send(8'h1B);

    send(8'h1C, 1'b1);
    expect_out(8'h45, 8'h30, 8'h03); send(8'h45);
    send(8'hF0);
    expect_out(8'h00, 8'h00, 8'h03); send(8'h45);

    n = 8'h03;
    for (int i = 0; i < 256; i++) begin
      n = n + 8'd1;
      expect_out(8'h16, 8'h31, n); send(8'h16);
      send(8'hF0);
      expect_out(8'h00, 8'h00, n); send(8'h16);
    end

    send(8'hE0);
    expect_out(8'h75, 8'h00, 8'h04); send(8'h75);

`ifdef PS2_FRAME_TIMEOUT_EN
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    repeat (TO_CYC + 100) @(posedge clk);
    expect_out(8'h1C, 8'h61, 8'h05); send(8'h1C);
`endif

    repeat (50) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_responses got %0d outstanding want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #20ms;
    $display("FAIL watchdog got timeout want completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
